// File: rtl/breathe_envelope_gen.sv
// Purpose: breathing-LED envelope (ATTACK ramp to peak, HOLD, DECAY ramp to 0) feeding the PWM duty input.
// Latency: an accepted trigger changes state on the same edge; the first level step lands TICK_DIV*rate_eff clocks later.
// Backpressure: none; trigger is ignored in ATTACK/HOLD and retriggers in DECAY. Optional macro ENV_AUTOLOOP_EN adds loop_en.
module breathe_envelope_gen #(
    parameter int LEVEL_W  = 6,
    parameter int TICK_DIV = 1000,
    parameter int PRE_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic [LEVEL_W-1:0] peak,
    input  logic [3:0]         rate,
    input  logic [3:0]         hold_len,
`ifdef ENV_AUTOLOOP_EN
    input  logic               loop_en,
`endif
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid,
    output logic               busy,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ATTACK = 2'd1,
        S_HOLD   = 2'd2,
        S_DECAY  = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
    localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [3:0]         stp_q, stp_d;
    logic [3:0]         hold_q, hold_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic [3:0]         rate_q, rate_d;
    logic [3:0]         hlen_q, hlen_d;
    logic               valid_q;
    logic               tick;
    logic               step;
    logic               accept;
    logic [3:0]         rate_m1;
    logic               loop_now;

    // A programmed 0 behaves as 1; return the effective value minus one.
    function automatic logic [3:0] eff_m1(input logic [3:0] x);
        return (x == 4'd0) ? 4'd0 : x - 4'd1;
    endfunction

`ifdef ENV_AUTOLOOP_EN
    assign loop_now = loop_en;
`else
    assign loop_now = 1'b0;
`endif

    assign rate_m1 = eff_m1(rate_q);
    assign tick    = (pre_q == PRE_LAST);
    assign step    = tick && (stp_q == rate_m1);

    // Next-state, level and counter logic; a trigger in DECAY overrides a coincident step.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        peak_d  = peak_q;
        rate_d  = rate_q;
        hlen_d  = hlen_q;
        accept  = 1'b0;
        pre_d   = tick ? '0 : pre_q + PRE_ONE;
        stp_d   = stp_q;
        if (tick) begin
            stp_d = (stp_q == rate_m1) ? 4'd0 : stp_q + 4'd1;
        end
        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                stp_d = '0;
                if (trigger && (peak != '0)) begin
                    accept  = 1'b1;
                    state_d = S_ATTACK;
                end
            end
            S_ATTACK: begin
                if (step) begin
                    level_d = level_q + LVL_ONE;
                    if (level_d == peak_q) begin
                        state_d = S_HOLD;
                        hold_d  = eff_m1(hlen_q);
                    end
                end
            end
            S_HOLD: begin
                if (step) begin
                    if (hold_q == 4'd0) begin
                        state_d = S_DECAY;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            end
            S_DECAY: begin
                if (trigger) begin
                    accept = 1'b1;
                    if (level_q < peak) begin
                        state_d = S_ATTACK;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = eff_m1(hold_len);
                    end
                end else if (step) begin
                    level_d = level_q - LVL_ONE;
                    if (level_d == '0) begin
                        state_d = loop_now ? S_ATTACK : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            peak_d = peak;
            rate_d = rate;
            hlen_d = hold_len;
            pre_d  = '0;
            stp_d  = '0;
        end
    end

    // State, counters and latched settings; the strobe marks any edge that moved the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            stp_q   <= '0;
            hold_q  <= '0;
            level_q <= '0;
            peak_q  <= '0;
            rate_q  <= '0;
            hlen_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            stp_q   <= stp_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            peak_q  <= peak_d;
            rate_q  <= rate_d;
            hlen_q  <= hlen_d;
            valid_q <= (level_d != level_q);
        end
    end

    assign level       = level_q;
    assign level_valid = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_breathe_envelope_gen.sv
// Purpose: self-checking bench for breathe_envelope_gen with directed vectors and a random phase against a step-count model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_breathe_envelope_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic [5:0] peak;
    logic [3:0] rate;
    logic [3:0] hold_len;
    logic       loop_en;
    logic [5:0] level;
    logic       level_valid;
    logic       busy;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;

    // Reference model: step = every TD*rate_eff clocks since the last counter clear.
    int m_state, m_level, m_peak, m_rate, m_hold, m_holdrem, m_since, m_valid;

    breathe_envelope_gen #(.LEVEL_W(6), .TICK_DIV(TD), .PRE_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .peak        (peak),
        .rate        (rate),
        .hold_len    (hold_len),
`ifdef ENV_AUTOLOOP_EN
        .loop_en     (loop_en),
`endif
        .level       (level),
        .level_valid (level_valid),
        .busy        (busy),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       trig;
        logic [5:0] pk;
        logic [3:0] rt;
        logic [3:0] hl;
        int         ncyc;
        int         lvl;
        int         st;
        int         bsy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic t, input int pk, input int rt, input int hl,
                       input int n, input int lv, input int st, input int bsy);
        vec_t v;
        v.trig = t; v.pk = 6'(pk); v.rt = 4'(rt); v.hl = 4'(hl);
        v.ncyc = n; v.lvl = lv; v.st = st; v.bsy = bsy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic latch_inputs();
        m_peak = int'(peak);
        m_rate = (rate == 0) ? 1 : int'(rate);
        m_hold = (hold_len == 0) ? 1 : int'(hold_len);
    endtask

    task automatic model_step();
        int  prev;
        bit  stp;
        bit  lp;
        prev = m_level;
        lp   = 1'b0;
`ifdef ENV_AUTOLOOP_EN
        lp = loop_en;
`endif
        if (rst) begin
            m_state = 0; m_level = 0; m_peak = 0; m_rate = 1; m_hold = 1;
            m_holdrem = 0; m_since = 0; m_valid = 0;
            return;
        end
        if (m_state == 0) begin
            m_since = 0;
            stp = 1'b0;
        end else begin
            m_since++;
            stp = ((m_since % (TD * m_rate)) == 0);
        end
        case (m_state)
            0: if (trigger && peak != 0) begin
                latch_inputs();
                m_since = 0;
                m_state = 1;
            end
            1: if (stp) begin
                m_level++;
                if (m_level == m_peak) begin
                    m_state = 2;
                    m_holdrem = m_hold;
                end
            end
            2: if (stp) begin
                m_holdrem--;
                if (m_holdrem == 0) m_state = 3;
            end
            default: begin
                if (trigger) begin
                    latch_inputs();
                    m_since = 0;
                    if (m_level < m_peak) m_state = 1;
                    else begin
                        m_state = 2;
                        m_holdrem = m_hold;
                    end
                end else if (stp) begin
                    m_level--;
                    if (m_level == 0) m_state = lp ? 1 : 0;
                end
            end
        endcase
        m_valid = (m_level != prev) ? 1 : 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        if (level_valid) vcount++;
        chk("model_level", int'(level), m_level);
        chk("model_state", int'(state_o), m_state);
        chk("model_valid", int'(level_valid), m_valid);
        chk("model_busy", int'(busy), (m_state != 0) ? 1 : 0);
    endtask

    initial begin
        int vbase;
        int vsnap;
        rst = 1'b1; trigger = 1'b1; peak = 6'd5; rate = 4'd1; hold_len = 4'd1; loop_en = 1'b0;
        m_state = 0; m_level = 0; m_peak = 0; m_rate = 1; m_hold = 1;
        m_holdrem = 0; m_since = 0; m_valid = 0;

        // Reset held with trigger asserted.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_level", int'(level), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_state", int'(state_o), 0);
            chk("rst_valid", int'(level_valid), 0);
        end
        rst = 1'b0; trigger = 1'b0;
        repeat (100) cycle();
        chk("idle_after_rst", int'(state_o), 0);

        // Basic envelope: peak 3, rate 1, hold 2.
        add(1, 3, 1, 2, 1, 0, 1, 1);
        add(0, 3, 1, 2, 3, 0, 1, 1);
        add(0, 3, 1, 2, 1, 1, 1, 1);
        add(0, 3, 1, 2, 4, 2, 1, 1);
        add(0, 3, 1, 2, 4, 3, 2, 1);
        add(0, 3, 1, 2, 4, 3, 2, 1);
        add(0, 3, 1, 2, 3, 3, 2, 1);
        add(0, 3, 1, 2, 1, 3, 3, 1);
        add(0, 3, 1, 2, 4, 2, 3, 1);
        add(0, 3, 1, 2, 4, 1, 3, 1);
        add(0, 3, 1, 2, 4, 0, 0, 0);
        // rate 0 / hold 0 treated as 1.
        add(1, 1, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 4, 1, 2, 1);
        add(0, 1, 0, 0, 4, 1, 3, 1);
        add(0, 1, 0, 0, 4, 0, 0, 0);
        // peak 0 trigger ignored.
        add(1, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 5, 0, 0, 0);
        // Trigger held through ATTACK/HOLD; retrigger coincident with the final DECAY step.
        add(1, 2, 1, 1, 1, 0, 1, 1);
        add(1, 2, 1, 1, 4, 1, 1, 1);
        add(1, 2, 1, 1, 4, 2, 2, 1);
        add(1, 2, 1, 1, 3, 2, 2, 1);
        add(0, 2, 1, 1, 1, 2, 3, 1);
        add(0, 2, 1, 1, 4, 1, 3, 1);
        add(0, 2, 1, 1, 3, 1, 3, 1);
        add(1, 2, 1, 1, 1, 1, 1, 1);
        add(0, 2, 1, 1, 4, 2, 2, 1);
        add(0, 2, 1, 1, 4, 2, 3, 1);
        add(0, 2, 1, 1, 8, 0, 0, 0);
        add(1, 1, 1, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 4, 1, 2, 1);
        add(0, 1, 1, 1, 4, 1, 3, 1);
        add(0, 1, 1, 1, 4, 0, 0, 0);
        // Retrigger in DECAY: up to a higher peak, then to HOLD with a lower peak.
        add(1, 5, 1, 1, 1, 0, 1, 1);
        add(0, 5, 1, 1, 20, 5, 2, 1);
        add(0, 5, 1, 1, 4, 5, 3, 1);
        add(0, 5, 1, 1, 12, 2, 3, 1);
        add(1, 6, 1, 1, 1, 2, 1, 1);
        add(0, 6, 1, 1, 16, 6, 2, 1);
        add(0, 1, 3, 7, 4, 6, 3, 1);
        add(0, 1, 3, 7, 8, 4, 3, 1);
        add(1, 2, 1, 1, 1, 4, 2, 1);
        add(0, 2, 1, 1, 4, 4, 3, 1);
        add(0, 2, 1, 1, 16, 0, 0, 0);

        vbase = vcount;
        vsnap = 0;
        foreach (vq[i]) begin
            trigger = vq[i].trig; peak = vq[i].pk; rate = vq[i].rt; hold_len = vq[i].hl;
            repeat (vq[i].ncyc) cycle();
            chk($sformatf("vec%0d_level", i), int'(level), vq[i].lvl);
            chk($sformatf("vec%0d_state", i), int'(state_o), vq[i].st);
            chk($sformatf("vec%0d_busy", i), int'(busy), vq[i].bsy);
            if (i == 10) chk("basic_valid_pulses", vcount - vbase, 6);
            if (i == 14) vsnap = vcount;
            if (i == 16) chk("peak0_no_strobe", vcount - vsnap, 0);
        end

        // Reset in the middle of ATTACK at level 3.
        trigger = 1'b1; peak = 6'd5; rate = 4'd1; hold_len = 4'd1;
        cycle();
        trigger = 1'b0;
        repeat (12) cycle();
        chk("pre_rst_level", int'(level), 3);
        rst = 1'b1;
        cycle();
        chk("midrst_level", int'(level), 0);
        chk("midrst_state", int'(state_o), 0);
        chk("midrst_valid", int'(level_valid), 0);
        rst = 1'b0;
        cycle();

`ifdef ENV_AUTOLOOP_EN
        // Continuous looping: 1,2,2,1,0,1,... with busy never dropping.
        loop_en = 1'b1; trigger = 1'b1; peak = 6'd2; rate = 4'd1; hold_len = 4'd1;
        cycle();
        trigger = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            chk("loop_busy", int'(busy), 1);
        end
        loop_en = 1'b0;
        repeat (30) cycle();
        chk("loop_off_idle", int'(state_o), 0);
`endif

        // Random phase against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            trigger  = ($urandom_range(0, 15) == 0);
            peak     = 6'($urandom_range(0, 7));
            rate     = 4'($urandom_range(0, 3));
            hold_len = 4'($urandom_range(0, 3));
`ifdef ENV_AUTOLOOP_EN
            if (($urandom_range(0, 99)) == 0) loop_en = ~loop_en;
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
